// File: rtl/n_term_loopback_pipe.sv
// rtl/n_term_loopback_pipe.sv - north-termination loopback with per-wire mode and frame forwarding pipe
module n_term_loopback_pipe #(
  parameter int NUM_WIRES       = 12,
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int STROBE_PIPE     = 1,
  parameter int CFG_FRAME       = 0
) (
  input  logic                       UserCLK,
  input  logic                       rst,
  input  logic [NUM_WIRES-1:0]       from_N,
  output logic [NUM_WIRES-1:0]       to_S,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
  output logic [FrameBitsPerRow-1:0] FrameData_O,
  output logic                       UserCLKo,
  output logic                       rsto,
  output logic                       cfg_done
);

  logic [2*NUM_WIRES-1:0] r_mode;
  logic [NUM_WIRES-1:0]   r_loop;
  logic [NUM_WIRES-1:0]   r_sticky;
  logic                   r_cfg_done;
  logic                   w_cfg_wr;

  assign w_cfg_wr = FrameStrobe[CFG_FRAME];
  assign UserCLKo = UserCLK;
  assign rsto     = rst;
  assign cfg_done = r_cfg_done;

  // A config write clears every sticky bit, overriding a coincident set.
  always_ff @(posedge UserCLK or negedge rst) begin
    if (!rst) begin
      r_mode     <= '0;
      r_loop     <= '0;
      r_sticky   <= '0;
      r_cfg_done <= 1'b0;
    end else begin
      r_loop <= from_N;
      if (w_cfg_wr) begin
        r_mode     <= FrameData[2*NUM_WIRES-1:0];
        r_cfg_done <= 1'b1;
        r_sticky   <= '0;
      end else begin
        r_sticky <= r_sticky | from_N;
      end
    end
  end

  always_comb begin
    to_S = '0;
    for (int i = 0; i < NUM_WIRES; i++) begin
      case (r_mode[2*i +: 2])
        2'b00:   to_S[i] = from_N[i];
        2'b01:   to_S[i] = r_loop[i];
        2'b10:   to_S[i] = 1'b0;
        default: to_S[i] = r_sticky[i];
      endcase
    end
  end

  generate
    if (STROBE_PIPE == 0) begin : g_nopipe
      assign FrameStrobe_O = FrameStrobe;
      assign FrameData_O   = FrameData;
    end else begin : g_pipe
      logic [MaxFramesPerCol-1:0] r_strb [STROBE_PIPE];
      logic [FrameBitsPerRow-1:0] r_data [STROBE_PIPE];

      always_ff @(posedge UserCLK or negedge rst) begin
        if (!rst) begin
          for (int k = 0; k < STROBE_PIPE; k++) begin
            r_strb[k] <= '0;
            r_data[k] <= '0;
          end
        end else begin
          r_strb[0] <= FrameStrobe;
          r_data[0] <= FrameData;
          for (int k = 1; k < STROBE_PIPE; k++) begin
            r_strb[k] <= r_strb[k-1];
            r_data[k] <= r_data[k-1];
          end
        end
      end

      assign FrameStrobe_O = r_strb[STROBE_PIPE-1];
      assign FrameData_O   = r_data[STROBE_PIPE-1];
    end
  endgenerate

endmodule

// File: doc/n_term_loopback_pipe.md
N_TERM_LOOPBACK_PIPE -- requirements
Module: n_term_loopback_pipe

Interface
REQ-001 Parameter NUM_WIRES, default 12: number of north-to-south loopback channels; SHALL satisfy 1 <= NUM_WIRES and 2*NUM_WIRES <= FrameBitsPerRow.
REQ-002 Parameter MaxFramesPerCol, default 20: FrameStrobe width.
REQ-003 Parameter FrameBitsPerRow, default 32: FrameData width.
REQ-004 Parameter STROBE_PIPE, default 1: register stages on FrameStrobe/FrameData forwarding; legal range 0..3.
REQ-005 Parameter CFG_FRAME, default 0: FrameStrobe index that writes this block's mode register; SHALL be < MaxFramesPerCol.
REQ-006 UserCLK  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-008 from_N  in  NUM_WIRES  loopback inputs from tile below.
REQ-009 to_S  out  NUM_WIRES  loopback outputs to tile below.
REQ-010 FrameStrobe  in  MaxFramesPerCol  configuration frame strobes.
REQ-011 FrameData  in  FrameBitsPerRow  configuration frame data.
REQ-012 FrameStrobe_O  out  MaxFramesPerCol  forwarded strobes.
REQ-013 FrameData_O  out  FrameBitsPerRow  forwarded data, aligned with FrameStrobe_O.
REQ-014 UserCLKo  out  1  buffered UserCLK; rsto  out  1  buffered rst (same polarity).
REQ-015 cfg_done  out  1  high once the mode register has been written since reset.

Function
REQ-016 Mode register mode[2*NUM_WIRES-1:0], 2 bits per wire i at bits [2i+1:2i]: 00 pass, 01 registered, 10 tie-low, 11 sticky.
REQ-017 Config write: on rising UserCLK with FrameStrobe[CFG_FRAME]=1 (unpipelined input), mode <= FrameData[2*NUM_WIRES-1:0]; cfg_done <= 1; new mode effective from the following cycle.
REQ-018 Strobe held high several cycles SHALL rewrite mode every cycle; last captured value wins.
REQ-019 Mode 00: to_S[i] = from_N[i] combinationally, zero latency.
REQ-020 Mode 01: to_S[i] = from_N[i] delayed exactly one UserCLK cycle via flop r[i].
REQ-021 Mode 10: to_S[i] = 0.
REQ-022 Mode 11: sticky flop s[i] sets on any cycle from_N[i]=1 at the rising edge, holds 1; to_S[i] = s[i].
REQ-023 s[i] SHALL clear on every config write cycle (regardless of new mode); if from_N[i]=1 in that same cycle, clear wins and s[i] next = 0.
REQ-024 r[i] SHALL sample from_N[i] every cycle in all modes, so switching to mode 01 presents the previous-cycle value immediately.
REQ-025 Forwarding: FrameStrobe_O and FrameData_O = inputs delayed STROBE_PIPE cycles through identical pipelines; STROBE_PIPE=0 is combinational passthrough.
REQ-026 UserCLKo = UserCLK, rsto = rst, combinational, no gating.

Reset
REQ-027 While rst=0: mode=0 (all pass), r=0, s=0, cfg_done=0, all forwarding pipeline stages=0, asynchronously.
REQ-028 During and after reset, to_S equals from_N (mode 00); FrameStrobe_O/FrameData_O read 0 until pipeline refills (STROBE_PIPE>0).
REQ-029 Reset asserted mid-write SHALL abort the write; first rising edge after rst=1 with strobe high performs a normal write.
REQ-030 No state other than REQ-027 items; reset deassertion requires no synchronisation internally (handled upstream).

Verification
REQ-031 Reset, from_N=12'hA5A -> to_S=12'hA5A same cycle, cfg_done=0, FrameStrobe_O=0.
REQ-032 Write FrameData=32'h0055_5555 (all wires mode 01) via FrameStrobe[0] -> cfg_done=1; from_N stepped 0->12'hFFF -> to_S=12'hFFF exactly one cycle later.
REQ-033 Mode 11 all wires, one-cycle pulse from_N[3]=1 -> to_S=12'h008 held; second config write -> to_S drops to 0 next cycle; pulse coinciding with write -> s stays 0.
REQ-034 STROBE_PIPE=2, FrameStrobe=20'h00004 one cycle, FrameData=32'hDEADBEEF -> both appear on outputs exactly 2 cycles later, aligned, one cycle wide.
REQ-035 Mode 10 on wire 0 only (FrameData=32'h2) -> to_S[0]=0 regardless of from_N[0]; other wires pass.
REQ-036 rst=0 asserted between clock edges after mode 01 config -> mode, cfg_done, r, pipeline cleared immediately; to_S reverts to combinational from_N.
